spike_rate_decoder: RTL and testbench
=====================================

Name: spike_rate_decoder

Overview:
- Output-side counterpart to the integrate-and-fire neuron: turns a bank of neuron spike lines back into numbers.
- Counts spikes per channel over a fixed window of clock cycles and latches the per-channel rate counts.
- Selects the winning (most active) channel and presents the result on a valid/ready output interface.
- Sits after the neuron array as the readout stage of the tiny SNN.

Parameters:
- NUM_CH, 4: number of spike input channels (>=2).
- WINDOW, 255: sampled cycles per counting window (1..2^16-1).
- CNT_W, 8: per-channel counter width in bits.
- IDX_W, $clog2(NUM_CH): width of the winner index.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  run enable; windows start and continue only while high.
- spike_in  in  NUM_CH  one spike bit per channel; bit i = neuron i fired this cycle.
- out_ready  in  1  consumer accepts the result.
- out_valid  out  1  result registers hold a completed window.
- counts_out  out  NUM_CH*CNT_W  per-channel counts; channel i at bits [i*CNT_W +: CNT_W].
- winner  out  IDX_W  index of the highest count.
- any_spike  out  1  at least one count in the window is non-zero.
- sat  out  NUM_CH  per-channel flag: that counter saturated during the window.
- busy  out  1  high while in COUNT.

Behaviour:
- Reset (asynchronous, rst=1):
  - All outputs, counters and the window counter go to 0.
  - State goes to IDLE.
  - Reset mid-window or mid-HOLD discards everything; no partial result is ever presented.
- States: IDLE, COUNT, HOLD.
- IDLE:
  - Spikes are ignored.
  - en=1 at edge t: clear counters and window_cnt, go to COUNT.
  - spike_in is sampled starting at edge t+1.
- COUNT:
  - busy=1.
  - On each edge, every channel with spike_in[i]=1 increments.
  - Increment saturates at 2^CNT_W-1; on saturation, set sat[i] (sticky for the window).
  - window_cnt increments by 1 each edge.
- Window end (edge where window_cnt==WINDOW-1):
  - The final sample is included.
  - The final counts, winner, any_spike and sat are registered into the output registers.
  - out_valid=1, state goes to HOLD.
  - Latency: en sampled at edge t gives out_valid high after edge t+WINDOW.
- Abort: en=0 during COUNT goes to IDLE on that edge. Counts are discarded and out_valid stays 0.
- Winner selection:
  - Combinational argmax over the final counts (incoming spike included).
  - Ties resolve to the lowest index.
  - All-zero counts give winner=0 and any_spike=0.
- HOLD:
  - Outputs stay stable while out_valid=1 and out_ready=0; spikes are ignored (not counted).
  - Handshake on an edge with out_valid & out_ready: out_valid drops.
    - If en=1: go to COUNT with counters cleared. The next window samples from the following edge, giving exactly one dead cycle between windows.
    - If en=0: go to IDLE.
  - counts_out, winner, any_spike and sat keep their last values after the handshake until the next window completes.
  - en=0 in HOLD does not drop out_valid; the result is still delivered.
- Arithmetic:
  - Counters are unsigned.
  - window_cnt width is 16 bits.
  - Comparisons are unsigned.

Decomposition:
- Shared package snn_pkg:
  - State enum (IDLE/COUNT/HOLD).
  - Default CNT_W and WINDOW constants, shared with the neuron array's spike-bus width constant.
- Sub-module spike_argmax:
  - Parameterised NUM_CH/CNT_W, purely combinational.
  - Lowest-index tie-break.
  - Outputs winner and any_spike.
- The top module holds the FSM, counters, window counter and output registers.

Test Plan:
- Reset: assert rst mid-COUNT with counts non-zero -> next cycle: out_valid=0, busy=0, counts_out=0, sat=0, winner=0; deassert and hold en=0 -> stays IDLE.
- Basic rate (NUM_CH=4, WINDOW=8, CNT_W=8): en raised at edge 0; ch2 spikes every cycle, ch0 on alternate cycles -> after edge 8: out_valid=1, counts {ch0=4, ch1=0, ch2=8, ch3=0}, winner=2, any_spike=1, sat=0.
- Tie and zero: ch1 and ch3 each fire 3 times in a window -> winner=1. Next window with no spikes -> counts all 0, winner=0, any_spike=0.
- Saturation: CNT_W=3, WINDOW=10, ch0 fires all 10 cycles -> counts_out ch0=7, sat=4'b0001, winner=0.
- Backpressure and back-to-back: out_ready=0 for 5 cycles in HOLD while all spike_in=1 -> outputs unchanged. Raise out_ready with en=1 -> out_valid drops, busy=1 next edge. The next window sees only post-handshake spikes.
- Abort: en drops after edge 4 of an 8-cycle window -> IDLE, out_valid never asserts. Re-raise en -> full fresh window with counts starting from 0.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared types and default sizes for the tiny SNN: the decoder FSM state
// and the widths shared between the neuron array and its readout stage.
package snn_pkg;

    localparam int SPIKE_BUS_W = 4;
    localparam int CNT_W_DEF   = 8;
    localparam int WINDOW_DEF  = 255;
    localparam int WIN_CNT_W   = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HOLD  = 2'd2
    } dec_state_t;

endpackage

// File: rtl/spike_argmax.sv
// Combinational argmax over a packed bank of unsigned rate counts.
// Ties go to the lowest channel index. An all-zero bank gives winner 0.
module spike_argmax #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8,
    parameter int IDX_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH*CNT_W-1:0] counts,
    output logic [IDX_W-1:0]        winner,
    output logic                    any_spike
);

    logic [CNT_W-1:0] best;

    always_comb begin
        // NOTE: blocking assignments, because best is updated and then read
        // again later in the same pass; defaults come first so nothing latches.
        best      = counts[CNT_W-1:0];
        winner    = '0;
        any_spike = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            // Strict greater-than keeps the earliest index on a tie.
            if (counts[i*CNT_W +: CNT_W] > best) begin
                best   = counts[i*CNT_W +: CNT_W];
                winner = IDX_W'(i);
            end
            if (counts[i*CNT_W +: CNT_W] != '0) begin
                any_spike = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spike_rate_decoder.sv
// Readout stage: counts spikes per channel over a fixed window, then holds the
// counts, the winning channel and saturation flags behind a valid/ready port.
module spike_rate_decoder
    import snn_pkg::*;
#(
    parameter int NUM_CH = SPIKE_BUS_W,
    parameter int WINDOW = WINDOW_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int IDX_W  = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [NUM_CH-1:0]       spike_in,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [NUM_CH*CNT_W-1:0] counts_out,
    output logic [IDX_W-1:0]        winner,
    output logic                    any_spike,
    output logic [NUM_CH-1:0]       sat,
    output logic                    busy
);

    localparam logic [CNT_W-1:0]     CNT_MAX     = '1;
    localparam logic [WIN_CNT_W-1:0] LAST_SAMPLE = WIN_CNT_W'(WINDOW - 1);

    dec_state_t             state, state_next;
    logic [NUM_CH*CNT_W-1:0] cnt, cnt_next;
    logic [NUM_CH-1:0]      sat_acc, sat_next;
    logic [WIN_CNT_W-1:0]   window_cnt;
    logic [IDX_W-1:0]       win_next;
    logic                   any_next;
    logic                   window_end;
    logic                   handshake;

    assign window_end = (window_cnt == LAST_SAMPLE);
    assign handshake  = out_valid & out_ready;
    assign busy       = (state == COUNT);

    // Counts as they will be after this edge's sample, so the window's final
    // spike is already included when the result is latched.
    always_comb begin
        cnt_next = cnt;
        sat_next = sat_acc;
        for (int i = 0; i < NUM_CH; i++) begin
            if (spike_in[i]) begin
                if (cnt[i*CNT_W +: CNT_W] == CNT_MAX) begin
                    sat_next[i] = 1'b1;
                end else begin
                    cnt_next[i*CNT_W +: CNT_W] = cnt[i*CNT_W +: CNT_W] + CNT_W'(1);
                end
            end
        end
    end

    spike_argmax #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W),
        .IDX_W  (IDX_W)
    ) u_argmax (
        .counts    (cnt_next),
        .winner    (win_next),
        .any_spike (any_next)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (en) state_next = COUNT;
            COUNT: begin
                if (!en)             state_next = IDLE;
                else if (window_end) state_next = HOLD;
            end
            HOLD:    if (handshake) state_next = en ? COUNT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            sat_acc    <= '0;
            window_cnt <= '0;
            out_valid  <= 1'b0;
            counts_out <= '0;
            winner     <= '0;
            any_spike  <= 1'b0;
            sat        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        cnt        <= '0;
                        sat_acc    <= '0;
                        window_cnt <= '0;
                    end
                end
                COUNT: begin
                    // An abort simply leaves; IDLE clears everything on restart.
                    if (en) begin
                        cnt        <= cnt_next;
                        sat_acc    <= sat_next;
                        window_cnt <= window_cnt + WIN_CNT_W'(1);
                        if (window_end) begin
                            counts_out <= cnt_next;
                            sat        <= sat_next;
                            winner     <= win_next;
                            any_spike  <= any_next;
                            out_valid  <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (handshake) begin
                        out_valid  <= 1'b0;
                        cnt        <= '0;
                        sat_acc    <= '0;
                        window_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Randomised bench for spike_rate_decoder: one 8-cycle/8-bit instance and one
// 10-cycle/3-bit instance, checked against a per-window spike-sum model.
module tb_spike_rate_decoder;

    logic        clk = 1'b0;
    logic        rst;

    logic        en_a, rdy_a, out_valid_a, any_a, busy_a;
    logic [3:0]  spike_a, sat_a;
    logic [31:0] counts_a;
    logic [1:0]  winner_a;

    logic        en_s, rdy_s, out_valid_s, any_s, busy_s;
    logic [3:0]  spike_s, sat_s;
    logic [11:0] counts_s;
    logic [1:0]  winner_s;

    int checks   = 0;
    int failures = 0;

    logic [3:0] hist[$];
    int         m_cnt[4];
    logic [3:0] m_sat;
    int         m_win;
    logic       m_any;

    always #5 clk = ~clk;

    spike_rate_decoder #(.NUM_CH(4), .WINDOW(8), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .en(en_a), .spike_in(spike_a), .out_ready(rdy_a),
        .out_valid(out_valid_a), .counts_out(counts_a), .winner(winner_a),
        .any_spike(any_a), .sat(sat_a), .busy(busy_a)
    );

    spike_rate_decoder #(.NUM_CH(4), .WINDOW(10), .CNT_W(3)) dut_s (
        .clk(clk), .rst(rst), .en(en_s), .spike_in(spike_s), .out_ready(rdy_s),
        .out_valid(out_valid_s), .counts_out(counts_s), .winner(winner_s),
        .any_spike(any_s), .sat(sat_s), .busy(busy_s)
    );

    // Reference: total spikes per channel across the window, clamped to maxv.
    task automatic model_window(input int maxv);
        int sum;
        int mx;
        mx    = 0;
        m_sat = '0;
        for (int i = 0; i < 4; i++) begin
            sum = 0;
            foreach (hist[k]) if (hist[k][i]) sum++;
            m_cnt[i] = (sum > maxv) ? maxv : sum;
            m_sat[i] = (sum > maxv);
            if (m_cnt[i] > mx) mx = m_cnt[i];
        end
        m_win = -1;
        for (int i = 0; i < 4; i++) if (m_win < 0 && m_cnt[i] == mx) m_win = i;
        m_any = (mx > 0);
    endtask

    function automatic logic [31:0] exp_counts(input int cw);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) r = r | (32'(m_cnt[i]) << (i * cw));
        return r;
    endfunction

    // Inputs change on the falling edge; outputs are read at the next one.
    task automatic step_a(input logic e, input logic [3:0] sp, input logic r);
        en_a = e; spike_a = sp; rdy_a = r;
        @(negedge clk);
    endtask

    task automatic step_s(input logic e, input logic [3:0] sp, input logic r);
        en_s = e; spike_s = sp; rdy_s = r;
        @(negedge clk);
    endtask

    task automatic run_window_a(input logic [31:0] pat);
        hist.delete();
        for (int k = 0; k < 8; k++) begin
            hist.push_back(pat[k*4 +: 4]);
            step_a(1'b1, pat[k*4 +: 4], 1'b0);
        end
        model_window(255);
    endtask

    task automatic run_window_s(input logic [39:0] pat);
        hist.delete();
        for (int k = 0; k < 10; k++) begin
            hist.push_back(pat[k*4 +: 4]);
            step_s(1'b1, pat[k*4 +: 4], 1'b0);
        end
        model_window(7);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en_a = 1'b0; spike_a = '0; rdy_a = 1'b0;
        en_s = 1'b0; spike_s = '0; rdy_s = 1'b0;
        @(negedge clk);
        checks++;
        if ({out_valid_a, busy_a, counts_a, winner_a, any_a, sat_a} !== 41'd0) begin
            failures++;
            $display("FAIL reset_a: got %h want 0", {out_valid_a, busy_a, counts_a, winner_a, any_a, sat_a});
        end
        checks++;
        if ({out_valid_s, busy_s, counts_s, winner_s, any_s, sat_s} !== 21'd0) begin
            failures++;
            $display("FAIL reset_s: got %h want 0", {out_valid_s, busy_s, counts_s, winner_s, any_s, sat_s});
        end
        rst = 1'b0;
        step_a(1'b0, 4'hF, 1'b1);
        step_a(1'b0, 4'hF, 1'b1);
        checks++;
        if ({busy_a, out_valid_a} !== 2'b00) begin
            failures++;
            $display("FAIL idle_after_reset: got busy/valid %b want 00", {busy_a, out_valid_a});
        end
    endtask

    task automatic test_basic();
        logic [3:0] sp;
        step_a(1'b1, 4'hF, 1'b0);
        checks++;
        if ({busy_a, out_valid_a} !== 2'b10) begin
            failures++;
            $display("FAIL basic_start: got busy/valid %b want 10", {busy_a, out_valid_a});
        end
        hist.delete();
        for (int k = 0; k < 8; k++) begin
            sp = 4'b0100 | ((k % 2 == 0) ? 4'b0001 : 4'b0000);
            hist.push_back(sp);
            step_a(1'b1, sp, 1'b0);
            if (k < 7) begin
                checks++;
                if (out_valid_a !== 1'b0) begin
                    failures++;
                    $display("FAIL basic_early_valid: cycle %0d got %b want 0", k, out_valid_a);
                end
            end
        end
        model_window(255);
        checks++;
        if ({out_valid_a, busy_a, counts_a, winner_a, any_a, sat_a} !== {2'b10, 32'h0008_0004, 2'd2, 1'b1, 4'h0}) begin
            failures++;
            $display("FAIL basic_result: got %h want %h", {out_valid_a, busy_a, counts_a, winner_a, any_a, sat_a},
                     {2'b10, 32'h0008_0004, 2'd2, 1'b1, 4'h0});
        end
        checks++;
        if ({counts_a, winner_a, any_a, sat_a} !== {exp_counts(8), 2'(m_win), m_any, m_sat}) begin
            failures++;
            $display("FAIL basic_model: got %h want %h", {counts_a, winner_a, any_a, sat_a},
                     {exp_counts(8), 2'(m_win), m_any, m_sat});
        end
    endtask

    task automatic test_tie_zero();
        step_a(1'b1, 4'hF, 1'b1);
        run_window_a(32'h8208_2082);
        checks++;
        if ({out_valid_a, winner_a, any_a} !== {1'b1, 2'd1, 1'b1}) begin
            failures++;
            $display("FAIL tie_winner: got valid/winner/any %b want 1011", {out_valid_a, winner_a, any_a});
        end
        checks++;
        if ({counts_a, sat_a} !== {exp_counts(8), m_sat}) begin
            failures++;
            $display("FAIL tie_counts: got %h want %h", {counts_a, sat_a}, {exp_counts(8), m_sat});
        end
        step_a(1'b1, 4'hF, 1'b1);
        run_window_a(32'h0);
        checks++;
        if ({out_valid_a, counts_a, winner_a, any_a, sat_a} !== {1'b1, 32'h0, 2'd0, 1'b0, 4'h0}) begin
            failures++;
            $display("FAIL zero_window: got %h want %h", {out_valid_a, counts_a, winner_a, any_a, sat_a},
                     {1'b1, 32'h0, 2'd0, 1'b0, 4'h0});
        end
    endtask

    task automatic test_back_to_back();
        step_a(1'b1, 4'hF, 1'b1);
        run_window_a($urandom());
        for (int c = 0; c < 5; c++) begin
            step_a((c == 2) ? 1'b0 : 1'b1, 4'hF, 1'b0);
            checks++;
            if ({out_valid_a, busy_a, counts_a, winner_a, any_a, sat_a} !== {2'b10, exp_counts(8), 2'(m_win), m_any, m_sat}) begin
                failures++;
                $display("FAIL hold_stable: stall %0d got %h want %h", c, {out_valid_a, busy_a, counts_a, winner_a, any_a, sat_a},
                         {2'b10, exp_counts(8), 2'(m_win), m_any, m_sat});
            end
        end
        step_a(1'b1, 4'hF, 1'b1);
        checks++;
        if ({out_valid_a, busy_a, counts_a} !== {2'b01, exp_counts(8)}) begin
            failures++;
            $display("FAIL handshake: got %h want %h", {out_valid_a, busy_a, counts_a}, {2'b01, exp_counts(8)});
        end
        run_window_a($urandom());
        checks++;
        if ({out_valid_a, counts_a, winner_a, any_a, sat_a} !== {1'b1, exp_counts(8), 2'(m_win), m_any, m_sat}) begin
            failures++;
            $display("FAIL b2b_window: got %h want %h", {out_valid_a, counts_a, winner_a, any_a, sat_a},
                     {1'b1, exp_counts(8), 2'(m_win), m_any, m_sat});
        end
    endtask

    task automatic test_random();
        int n;
        for (int w = 0; w < 6; w++) begin
            step_a(1'b1, 4'($urandom()), 1'b1);
            checks++;
            if ({out_valid_a, busy_a} !== 2'b01) begin
                failures++;
                $display("FAIL rand_handshake: window %0d got %b want 01", w, {out_valid_a, busy_a});
            end
            run_window_a($urandom());
            checks++;
            if ({out_valid_a, counts_a, winner_a, any_a, sat_a} !== {1'b1, exp_counts(8), 2'(m_win), m_any, m_sat}) begin
                failures++;
                $display("FAIL rand_window: window %0d got %h want %h", w, {out_valid_a, counts_a, winner_a, any_a, sat_a},
                         {1'b1, exp_counts(8), 2'(m_win), m_any, m_sat});
            end
            n = $urandom_range(0, 3);
            for (int c = 0; c < n; c++) begin
                step_a(1'($urandom_range(0, 1)), 4'hF, 1'b0);
                checks++;
                if ({out_valid_a, counts_a, winner_a} !== {1'b1, exp_counts(8), 2'(m_win)}) begin
                    failures++;
                    $display("FAIL rand_stall: window %0d got %h want %h", w, {out_valid_a, counts_a, winner_a},
                             {1'b1, exp_counts(8), 2'(m_win)});
                end
            end
        end
    endtask

    task automatic test_abort();
        step_a(1'b0, 4'h0, 1'b1);
        checks++;
        if ({out_valid_a, busy_a, counts_a} !== {2'b00, exp_counts(8)}) begin
            failures++;
            $display("FAIL to_idle: got %h want %h", {out_valid_a, busy_a, counts_a}, {2'b00, exp_counts(8)});
        end
        step_a(1'b0, 4'hF, 1'b0);
        step_a(1'b1, 4'hF, 1'b0);
        for (int k = 0; k < 4; k++) step_a(1'b1, 4'($urandom()), 1'b0);
        step_a(1'b0, 4'hF, 1'b0);
        checks++;
        if ({out_valid_a, busy_a} !== 2'b00) begin
            failures++;
            $display("FAIL abort_idle: got valid/busy %b want 00", {out_valid_a, busy_a});
        end
        for (int c = 0; c < 10; c++) begin
            step_a(1'b0, 4'hF, 1'b0);
            checks++;
            if (out_valid_a !== 1'b0) begin
                failures++;
                $display("FAIL abort_no_valid: cycle %0d got %b want 0", c, out_valid_a);
            end
        end
        step_a(1'b1, 4'hF, 1'b0);
        run_window_a($urandom());
        checks++;
        if ({out_valid_a, counts_a, winner_a, any_a, sat_a} !== {1'b1, exp_counts(8), 2'(m_win), m_any, m_sat}) begin
            failures++;
            $display("FAIL abort_fresh: got %h want %h", {out_valid_a, counts_a, winner_a, any_a, sat_a},
                     {1'b1, exp_counts(8), 2'(m_win), m_any, m_sat});
        end
    endtask

    task automatic test_saturation();
        logic [39:0] pat;
        for (int k = 0; k < 10; k++) begin
            pat[k*4 +: 4] = {1'b0, 1'($urandom_range(0, 1)), (k < 5) ? 1'b1 : 1'b0, 1'b1};
        end
        step_s(1'b1, 4'hF, 1'b0);
        run_window_s(pat);
        checks++;
        if ({out_valid_s, counts_s[2:0], sat_s[0], winner_s} !== {1'b1, 3'd7, 1'b1, 2'd0}) begin
            failures++;
            $display("FAIL sat_ch0: got %b want %b", {out_valid_s, counts_s[2:0], sat_s[0], winner_s}, {1'b1, 3'd7, 1'b1, 2'd0});
        end
        checks++;
        if ({counts_s, winner_s, any_s, sat_s} !== {12'(exp_counts(3)), 2'(m_win), m_any, m_sat}) begin
            failures++;
            $display("FAIL sat_model: got %h want %h", {counts_s, winner_s, any_s, sat_s},
                     {12'(exp_counts(3)), 2'(m_win), m_any, m_sat});
        end
        step_s(1'b1, 4'h0, 1'b1);
        run_window_s({8'($urandom()), 32'($urandom())});
        checks++;
        if ({out_valid_s, counts_s, winner_s, any_s, sat_s} !== {1'b1, 12'(exp_counts(3)), 2'(m_win), m_any, m_sat}) begin
            failures++;
            $display("FAIL sat_random: got %h want %h", {out_valid_s, counts_s, winner_s, any_s, sat_s},
                     {1'b1, 12'(exp_counts(3)), 2'(m_win), m_any, m_sat});
        end
        step_s(1'b1, 4'h0, 1'b1);
        run_window_s({40{1'b1}});
        checks++;
        if ({out_valid_s, counts_s, winner_s, any_s, sat_s} !== {1'b1, 12'hFFF, 2'd0, 1'b1, 4'hF}) begin
            failures++;
            $display("FAIL sat_all: got %h want %h", {out_valid_s, counts_s, winner_s, any_s, sat_s},
                     {1'b1, 12'hFFF, 2'd0, 1'b1, 4'hF});
        end
        step_s(1'b0, 4'h0, 1'b1);
    endtask

    task automatic test_reset_mid();
        step_a(1'b1, 4'hF, 1'b1);
        for (int k = 0; k < 4; k++) step_a(1'b1, 4'hF, 1'b0);
        rst = 1'b1;
        #1;
        checks++;
        if ({out_valid_a, busy_a, counts_a, winner_a, any_a, sat_a} !== 41'd0) begin
            failures++;
            $display("FAIL reset_mid_a: got %h want 0", {out_valid_a, busy_a, counts_a, winner_a, any_a, sat_a});
        end
        checks++;
        if ({out_valid_s, counts_s, winner_s, any_s, sat_s} !== 20'd0) begin
            failures++;
            $display("FAIL reset_mid_s: got %h want 0", {out_valid_s, counts_s, winner_s, any_s, sat_s});
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step_a(1'b0, 4'hF, 1'b1);
            checks++;
            if ({out_valid_a, busy_a, counts_a} !== 34'd0) begin
                failures++;
                $display("FAIL reset_stay_idle: cycle %0d got %h want 0", c, {out_valid_a, busy_a, counts_a});
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_tie_zero();
        test_back_to_back();
        test_random();
        test_abort();
        test_saturation();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
